// File: rtl/dot_prod_datapath.sv
// Operand store and signed multiply-accumulate datapath for the dot-product accelerator.
// Holds vectors A and B, walks the element index under controller gating and captures the final sum.
module dot_prod_datapath #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int ACC_W  = 2*DATA_W+ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W:0]   vec_len,
    input  logic              ldi,
    input  logic              compute,
    input  logic              en_sum,
    output logic              vector_valid,
    output logic              zi,
    output logic [ACC_W-1:0]  result
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

    logic        [DATA_W-1:0]   r_vecA [DEPTH];
    logic        [DATA_W-1:0]   r_vecB [DEPTH];
    logic        [ADDR_W:0]     r_idx;
    logic        [ADDR_W:0]     r_len;
    logic                       r_opValid;
    logic signed [DATA_W-1:0]   r_opA;
    logic signed [DATA_W-1:0]   r_opB;
    logic        [ACC_W-1:0]    r_acc;
    logic        [ACC_W-1:0]    r_result;

    logic        [ADDR_W:0]     w_idxNext;
    logic        [ADDR_W:0]     w_lenMin;
    logic        [DATA_W-1:0]   w_fetchA;
    logic        [DATA_W-1:0]   w_fetchB;
    logic signed [2*DATA_W-1:0] w_prod;
    logic        [ACC_W-1:0]    w_accNext;
    logic                       w_advance;
    logic                       w_accum;
    logic                       w_last;

    assign w_lenMin     = (vec_len > DEPTH_L) ? DEPTH_L : vec_len;
    assign vector_valid = r_opValid && (r_idx < r_len);
    assign w_last       = compute && vector_valid && (r_idx == r_len - ONE_L);
    assign zi           = (r_len == '0) || w_last;
    assign w_advance    = !ldi && compute && en_sum && vector_valid;
    assign w_accum      = !ldi && en_sum && vector_valid;
    assign w_prod       = r_opA * r_opB;
    assign w_accNext    = r_acc + {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
    assign w_idxNext    = ldi ? '0 : (w_advance ? r_idx + ONE_L : r_idx);
    assign result       = r_result;

    // Operands are prefetched for the index the counter will hold next cycle;
    // an index past the last entry fetches zero since it can never be consumed.
    always_comb begin
        w_fetchA = '0;
        w_fetchB = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_idxNext == (ADDR_W+1)'(k)) begin
                w_fetchA = r_vecA[k];
                w_fetchB = r_vecB[k];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_vecA[k] <= '0;
                r_vecB[k] <= '0;
            end
            r_idx     <= '0;
            r_len     <= '0;
            r_opValid <= 1'b0;
            r_opA     <= '0;
            r_opB     <= '0;
            r_acc     <= '0;
            r_result  <= '0;
        end else begin
            if (wr_en) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (wr_addr == ADDR_W'(k)) begin
                        if (wr_sel) r_vecB[k] <= wr_data;
                        else        r_vecA[k] <= wr_data;
                    end
                end
            end
            r_idx     <= w_idxNext;
            r_opA     <= w_fetchA;
            r_opB     <= w_fetchB;
            r_opValid <= !ldi;
            if (ldi) begin
                r_len <= w_lenMin;
                r_acc <= '0;
            end else if (w_accum) begin
                r_acc <= w_accNext;
            end
            // An empty vector completes with a zero result on its first compute cycle.
            if (!ldi && compute && (r_len == '0)) begin
                r_result <= '0;
            end else if (!ldi && w_last) begin
                r_result <= w_accNext;
            end
        end
    end

endmodule

// File: tb/tb_dot_prod_datapath.sv
// Directed testbench for dot_prod_datapath with hand-computed dot products.
module tb_dot_prod_datapath;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int ACC_W  = 36;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     wr_en;
    logic                     wr_sel;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [ADDR_W:0]          vec_len;
    logic                     ldi;
    logic                     compute;
    logic                     en_sum;
    logic                     vector_valid;
    logic                     zi;
    logic signed [ACC_W-1:0]  result;

    int errors = 0;
    int checks = 0;

    dot_prod_datapath #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .vec_len     (vec_len),
        .ldi         (ldi),
        .compute     (compute),
        .en_sum      (en_sum),
        .vector_valid(vector_valid),
        .zi          (zi),
        .result      (result)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic sel, input int addr, input int data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = ADDR_W'(addr);
        wr_data = DATA_W'(data);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic ldiPulse(input int len);
        vec_len = (ADDR_W+1)'(len);
        ldi     = 1'b1;
        tick();
        ldi     = 1'b0;
    endtask

    // Load, wait one cycle, then hold compute until zi; count consumed elements.
    task automatic runDot(input string tag, input int len, input int expCount, input longint expResult);
        int  n;
        bit  done;
        ldiPulse(len);
        #1 checkOutput({tag, " vv after ldi"}, longint'(vector_valid), 0);
        tick();
        checkOutput({tag, " vv 1 cycle later"}, longint'(vector_valid), (len != 0) ? 1 : 0);
        compute = 1'b1;
        en_sum  = 1'b1;
        n       = 0;
        done    = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (vector_valid) n++;
            if (zi) done = 1'b1;
            tick();
        end
        checkOutput({tag, " zi seen"}, longint'(done), 1);
        checkOutput({tag, " count"}, longint'(n), longint'(expCount));
        checkOutput({tag, " result"}, longint'(result), expResult);
        checkOutput({tag, " vv after"}, longint'(vector_valid), 0);
        tick();
        checkOutput({tag, " result held"}, longint'(result), expResult);
        compute = 1'b0;
        en_sum  = 1'b0;
    endtask

    initial begin
        int highs;
        int pattern [5] = '{1, 0, 1, 0, 1};
        reset_n = 1'b0;
        wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        vec_len = '0; ldi = 1'b0; compute = 1'b0; en_sum = 1'b0;
        #22;
        checkOutput("reset vv", longint'(vector_valid), 0);
        checkOutput("reset zi", longint'(zi), 1);
        checkOutput("reset result", longint'(result), 0);
        reset_n = 1'b1;
        tick();

        $display("[TB] basic dot product");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, k, k + 1);
            applyStimulus(1'b1, k, k + 5);
        end
        runDot("t1", 4, 4, 70);

        $display("[TB] back-to-back runs");
        ldiPulse(4);
        tick();
        tick();
        checkOutput("t5 result idle", longint'(result), 70);
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, k, 1);
        runDot("t5", 4, 4, 10);

        $display("[TB] signed operands");
        applyStimulus(1'b0, 0, -3);
        applyStimulus(1'b0, 1, 32767);
        applyStimulus(1'b1, 0, 4);
        applyStimulus(1'b1, 1, -2);
        runDot("t2", 2, 2, -65546);

        $display("[TB] gapped compute");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, k, 2);
            applyStimulus(1'b1, k, 3);
        end
        ldiPulse(3);
        tick();
        highs = 0;
        for (int k = 0; k < 5; k++) begin
            compute = pattern[k][0];
            en_sum  = pattern[k][0];
            #1;
            checkOutput($sformatf("t4 zi step%0d", k), longint'(zi),
                        (pattern[k] == 1 && highs == 2) ? 1 : 0);
            if (pattern[k] == 1) highs++;
            tick();
        end
        compute = 1'b0;
        en_sum  = 1'b0;
        checkOutput("t4 result", longint'(result), 18);
        checkOutput("t4 vv after", longint'(vector_valid), 0);

        $display("[TB] empty and oversize vectors");
        runDot("t3 empty", 0, 0, 0);
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(1'b0, k, k + 1);
            applyStimulus(1'b1, k, 1);
        end
        runDot("t3 clamp", 20, 16, 136);

        $display("[TB] reset mid-operation");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, k, k + 1);
            applyStimulus(1'b1, k, k + 5);
        end
        ldiPulse(4);
        tick();
        compute = 1'b1;
        en_sum  = 1'b1;
        tick();
        tick();
        checkOutput("t6 vv before reset", longint'(vector_valid), 1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("t6 vv in reset", longint'(vector_valid), 0);
        checkOutput("t6 zi in reset", longint'(zi), 1);
        checkOutput("t6 result in reset", longint'(result), 0);
        compute = 1'b0;
        en_sum  = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        runDot("t6 cleared", 4, 4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
